up_tpl_profile_ctrl: RTL and testbench
======================================

# up_tpl_profile_ctrl

Parametrised transport-layer control slave on the internal `up_*` register bus, sitting beside the ADC/DAC common and channel register blocks. It generalises the single-step profile register with several additions:
- a multi-profile JESD parameter readback table;
- a request/acknowledge profile-switch handshake towards the datapath, with timeout;
- sticky error status;
- per-channel saturating PN-error event counters.

Everything runs in the `up_clk` domain. Datapath status inputs arrive already synchronised.

## Interface
Parameters:
- `COMMON_ID`, 2'h0: address window select; block decodes `up_waddr[9:8]`/`up_raddr[9:8] == COMMON_ID`.
- `NUM_PROFILES`, 1: JESD profiles supported, 1..16.
- `NUM_CHANNELS`, 1: PN counter channels, 1..64.
- `CNT_WIDTH`, 16: PN counter width, 1..32.
- `TIMEOUT_CYCLES`, 1024: profile handshake timeout in `up_clk` cycles, ≥2.

Ports:
- `up_clk`  in  1  register/bus clock.
- `up_rstn`  in  1  reset; asynchronous assert, active-low.
- `up_wreq`  in  1  write strobe (1 cycle).
- `up_waddr`  in  10  word address.
- `up_wdata`  in  32  write data.
- `up_wack`  out  1  write acknowledge.
- `up_rreq`  in  1  read strobe (1 cycle).
- `up_raddr`  in  10  word address.
- `up_rdata`  out  32  read data; zero when not acknowledging.
- `up_rack`  out  1  read acknowledge.
- `jesd_m`, `jesd_l`, `jesd_s`, `jesd_f`, `jesd_n`, `jesd_np`  in  NUM_PROFILES*8 each  per-profile parameters; profile p occupies bits [8p+7:8p].
- `pn_err`  in  NUM_CHANNELS  per-channel PN error level, `up_clk` domain.
- `profile_req`  out  1  profile switch request.
- `profile_req_sel`  out  4  requested profile index.
- `profile_ack`  in  1  datapath acceptance of request.
- `up_profile_sel`  out  4  active profile index.

## Operation
Register map (offset within window; RW = read/write, RO = read-only, W1C = write-1-to-clear, WO = write-only):
- 0x00 RO: VERSION, 32'h0001_0061.
- 0x01 RW: SCRATCH, resets to 0.
- 0x02 RO: {16'b0, NUM_CHANNELS[7:0], NUM_PROFILES[7:0]}.
- 0x04 RW: PROFILE_SEL; read returns {28'b0, `profile_req_sel`}.
- 0x05 status:
  - [3:0] active profile, RO;
  - [8] busy, RO;
  - [9] timeout, W1C;
  - [10] range error, W1C;
  - [11] busy error, W1C.
- 0x08 WO: PN clear, channels 0..31, one bit per channel. 0x09 WO: PN clear, channels 32..63. Both read 0.
- 0x10+2p RO: {F,S,L,M} of profile p, bytes [31:24]..[7:0], for p < NUM_PROFILES; else 0.
- 0x11+2p RO: {16'b0, NP, N} of profile p.
- 0x40+c RO: PN counter c, zero-extended, for c < NUM_CHANNELS; else 0.
- Unmapped in-window addresses: acked; reads return 0; writes have no effect.

Profile FSM, states IDLE, REQ:
- IDLE, write to 0x04 with `wdata[3:0]` < NUM_PROFILES:
  - latch `profile_req_sel`;
  - assert `profile_req`;
  - clear the timeout counter;
  - go to REQ.
- IDLE, write to 0x04 with `wdata[3:0]` ≥ NUM_PROFILES: set the range sticky; no request issued.
- REQ, `profile_ack`=1:
  - drop `profile_req`;
  - `up_profile_sel` ← `profile_req_sel`;
  - go to IDLE.
- REQ, counter reaches TIMEOUT_CYCLES-1 without ack:
  - drop `profile_req`;
  - set the timeout sticky;
  - `up_profile_sel` unchanged;
  - go to IDLE.
- REQ, write to 0x04: ignored; set the busy-error sticky.
- Busy bit = (state == REQ).
- A request to the already-active profile still runs the full handshake.

PN counters:
- Edge detect: register `pn_err`; count on 0→1 transitions only.
- Saturate at 2^CNT_WIDTH−1, never wrap.
- A clear write and an edge in the same cycle give count 0.
- W1C set-and-clear in the same cycle: the set wins.

## Timing
- `up_wack`/`up_rack` assert exactly 1 cycle after an in-window `up_wreq`/`up_rreq`, for 1 cycle. `up_rdata` is valid in the `up_rack` cycle and 0 otherwise.
- Register write effects are visible from the cycle after `up_wreq`. `profile_req` rises in the `up_wack` cycle.
- `up_profile_sel` updates 1 cycle after the `profile_ack` sample. `profile_req` is low in that same cycle.
- Timeout: `profile_req` is high for exactly TIMEOUT_CYCLES cycles.
- PN count increments 2 cycles after a `pn_err` rising edge (1 cycle edge register, 1 cycle count).
- Reset values: every output 0. All counters, stickies, SCRATCH and `pn_err` history 0. FSM in IDLE.
- Reset asserted mid-handshake drops `profile_req` immediately (asynchronous) and discards the request.

## Test plan
- Bus: write 0xA5A5_5A5A to 0x01, read back the same value. Read 0x00 → 0x0001_0061. Reads of an out-of-window COMMON_ID → no `up_rack`, `up_rdata` 0.
- NUM_PROFILES=4, write 2 to 0x04, ack 3 cycles later:
  - `profile_req` high 4 cycles;
  - `up_profile_sel`=2;
  - 0x05 reads 0x002.
- Write 5 (NUM_PROFILES=4) → no `profile_req`; 0x05 bit10=1. Write 0x400 to 0x05 → bit10=0.
- TIMEOUT_CYCLES=16, never ack:
  - `profile_req` high 16 cycles;
  - 0x05 bit9=1;
  - `up_profile_sel` unchanged.
  - A second write to 0x04 during REQ sets bit11.
- CNT_WIDTH=4, 20 pulses on `pn_err[1]` → 0x41 reads 15. Hold `pn_err[1]` high 10 cycles → +1 only. Write 0x2 to 0x08 → 0x41 reads 0. Clear coincident with an edge → 0.
- Assert `up_rstn` while in REQ → `profile_req` 0 without a clock edge; after release all registers read reset values.

Source files
------------

// File: rtl/up_tpl_profile_ctrl.sv
// Transport-layer control slave: register window, JESD profile table, profile switch handshake, PN counters.
// Latency: up_wack/up_rack one cycle after the strobe; PN counts two cycles after a pn_err rising edge.
// Backpressure: none; every in-window access is acknowledged, profile writes while busy are dropped and flagged.
module up_tpl_profile_ctrl #(
  parameter logic [1:0] COMMON_ID      = 2'h0,
  parameter int         NUM_PROFILES   = 1,
  parameter int         NUM_CHANNELS   = 1,
  parameter int         CNT_WIDTH      = 16,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                      up_clk,
  input  logic                      up_rstn,
  input  logic                      up_wreq,
  input  logic [9:0]                up_waddr,
  input  logic [31:0]               up_wdata,
  output logic                      up_wack,
  input  logic                      up_rreq,
  input  logic [9:0]                up_raddr,
  output logic [31:0]               up_rdata,
  output logic                      up_rack,
  input  logic [NUM_PROFILES*8-1:0] jesd_m,
  input  logic [NUM_PROFILES*8-1:0] jesd_l,
  input  logic [NUM_PROFILES*8-1:0] jesd_s,
  input  logic [NUM_PROFILES*8-1:0] jesd_f,
  input  logic [NUM_PROFILES*8-1:0] jesd_n,
  input  logic [NUM_PROFILES*8-1:0] jesd_np,
  input  logic [NUM_CHANNELS-1:0]   pn_err,
  output logic                      profile_req,
  output logic [3:0]                profile_req_sel,
  input  logic                      profile_ack,
  output logic [3:0]                up_profile_sel
);

  localparam logic [31:0]          VERSION  = 32'h0001_0061;
  localparam int                   TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       wr_en;
  logic       rd_en;
  logic [7:0] waddr;
  logic [7:0] raddr;
  logic       wr_scratch;
  logic       wr_psel;
  logic       wr_status;
  logic       wr_pnclr0;
  logic       wr_pnclr1;

  assign wr_en      = up_wreq & (up_waddr[9:8] == COMMON_ID);
  assign rd_en      = up_rreq & (up_raddr[9:8] == COMMON_ID);
  assign waddr      = up_waddr[7:0];
  assign raddr      = up_raddr[7:0];
  assign wr_scratch = wr_en & (waddr == 8'h01);
  assign wr_psel    = wr_en & (waddr == 8'h04);
  assign wr_status  = wr_en & (waddr == 8'h05);
  assign wr_pnclr0  = wr_en & (waddr == 8'h08);
  assign wr_pnclr1  = wr_en & (waddr == 8'h09);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 wack_q;
  logic                 rack_q;
  logic [31:0]          rdata_q;
  logic [31:0]          rdata_d;
  logic [31:0]          scratch_q;
  state_e               state_q;
  state_e               state_d;
  logic [TW-1:0]        tmo_cnt_q;
  logic [TW-1:0]        tmo_cnt_d;
  logic [3:0]           req_sel_q;
  logic [3:0]           req_sel_d;
  logic [3:0]           sel_q;
  logic [3:0]           sel_d;
  logic                 set_tmo;
  logic                 set_rng;
  logic                 set_berr;
  logic                 sel_in_range;
  // sticky bits: [2] busy error, [1] range error, [0] timeout
  logic [2:0]           sticky_q;
  logic [2:0]           sticky_d;
  logic [2:0]           sticky_clr;
  logic [NUM_CHANNELS-1:0] pn_err_q;
  logic [NUM_CHANNELS-1:0] pn_edge_q;
  logic [NUM_CHANNELS-1:0] pn_clr;
  logic [CNT_WIDTH-1:0]    pn_cnt_q [NUM_CHANNELS];
  logic [4:0]           prof_off;

  assign sel_in_range = ({28'd0, up_wdata[3:0]} < NUM_PROFILES);

  // Bus handshake: one-cycle acks, read data held to zero outside the ack cycle
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      wack_q  <= 1'b0;
      rack_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      wack_q  <= wr_en;
      rack_q  <= rd_en;
      rdata_q <= rd_en ? rdata_d : 32'd0;
    end
  end

  // Scratch register
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      scratch_q <= '0;
    end else if (wr_scratch) begin
      scratch_q <= up_wdata;
    end
  end

  // Profile FSM and sticky registers
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= '0;
      req_sel_q <= '0;
      sel_q     <= '0;
      sticky_q  <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      req_sel_q <= req_sel_d;
      sel_q     <= sel_d;
      sticky_q  <= sticky_d;
    end
  end

  // Profile FSM next state; an ack on the last timeout cycle still completes the switch
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    req_sel_d = req_sel_q;
    sel_d     = sel_q;
    set_tmo   = 1'b0;
    set_rng   = 1'b0;
    set_berr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_psel) begin
          if (sel_in_range) begin
            req_sel_d = up_wdata[3:0];
            tmo_cnt_d = '0;
            state_d   = S_REQ;
          end else begin
            set_rng = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (wr_psel) begin
          set_berr = 1'b1;
        end
        if (profile_ack) begin
          sel_d   = req_sel_q;
          state_d = S_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          set_tmo = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky update: a hardware set in the same cycle as a W1C clear keeps the bit set
  always_comb begin
    sticky_clr = wr_status ? up_wdata[11:9] : 3'b000;
    sticky_d   = (sticky_q & ~sticky_clr) | {set_berr, set_rng, set_tmo};
  end

  // PN clear strobes, one bit per channel across two 32-bit registers
  always_comb begin
    pn_clr = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (c < 32) begin
        pn_clr[c] = wr_pnclr0 & up_wdata[c % 32];
      end else begin
        pn_clr[c] = wr_pnclr1 & up_wdata[c % 32];
      end
    end
  end

  // PN rising-edge detect, registered so counting happens the following cycle
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      pn_err_q  <= '0;
      pn_edge_q <= '0;
    end else begin
      pn_err_q  <= pn_err;
      pn_edge_q <= pn_err & ~pn_err_q;
    end
  end

  // Saturating PN counters; a clear beats a coincident count
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        pn_cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (pn_clr[c]) begin
          pn_cnt_q[c] <= '0;
        end else if (pn_edge_q[c] && (pn_cnt_q[c] != CNT_MAX)) begin
          pn_cnt_q[c] <= pn_cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Read mux; unmapped offsets and absent profiles/channels read zero
  always_comb begin
    rdata_d  = '0;
    prof_off = 5'(raddr - 8'h10);
    case (raddr)
      8'h00: rdata_d = VERSION;
      8'h01: rdata_d = scratch_q;
      8'h02: rdata_d = {16'd0, 8'(NUM_CHANNELS), 8'(NUM_PROFILES)};
      8'h04: rdata_d = {28'd0, req_sel_q};
      8'h05: rdata_d = {20'd0, sticky_q, (state_q == S_REQ), 4'd0, sel_q};
      default: rdata_d = '0;
    endcase
    if ((raddr >= 8'h10) && (raddr < 8'h30)) begin
      for (int p = 0; p < NUM_PROFILES; p++) begin
        if (prof_off[4:1] == 4'(p)) begin
          if (prof_off[0]) begin
            rdata_d = {16'd0, jesd_np[8*p +: 8], jesd_n[8*p +: 8]};
          end else begin
            rdata_d = {jesd_f[8*p +: 8], jesd_s[8*p +: 8], jesd_l[8*p +: 8], jesd_m[8*p +: 8]};
          end
        end
      end
    end
    if (raddr[7:6] == 2'b01) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (raddr[5:0] == 6'(c)) begin
          rdata_d = 32'(pn_cnt_q[c]);
        end
      end
    end
  end

  assign up_wack         = wack_q;
  assign up_rack         = rack_q;
  assign up_rdata        = rdata_q;
  assign profile_req     = (state_q == S_REQ);
  assign profile_req_sel = req_sel_q;
  assign up_profile_sel  = sel_q;

endmodule

// File: tb/tb_up_tpl_profile_ctrl.sv
module tb_up_tpl_profile_ctrl;

  localparam logic [1:0] WIN  = 2'h1;
  localparam int         NP   = 4;
  localparam int         NC   = 4;
  localparam int         CW   = 4;
  localparam int         TMO  = 16;
  localparam int         CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            up_wreq = 1'b0;
  logic [9:0]      up_waddr = '0;
  logic [31:0]     up_wdata = '0;
  logic            up_wack;
  logic            up_rreq = 1'b0;
  logic [9:0]      up_raddr = '0;
  logic [31:0]     up_rdata;
  logic            up_rack;
  logic [NP*8-1:0] jesd_m, jesd_l, jesd_s, jesd_f, jesd_n, jesd_np;
  logic [NC-1:0]   pn_err = '0;
  logic            profile_req;
  logic [3:0]      profile_req_sel;
  logic            profile_ack = 1'b0;
  logic [3:0]      up_profile_sel;

  up_tpl_profile_ctrl #(
    .COMMON_ID(WIN), .NUM_PROFILES(NP), .NUM_CHANNELS(NC),
    .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .up_clk(clk), .up_rstn(rstn),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .jesd_m(jesd_m), .jesd_l(jesd_l), .jesd_s(jesd_s), .jesd_f(jesd_f),
    .jesd_n(jesd_n), .jesd_np(jesd_np),
    .pn_err(pn_err),
    .profile_req(profile_req), .profile_req_sel(profile_req_sel),
    .profile_ack(profile_ack), .up_profile_sel(up_profile_sel)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: register-map semantics applied once per clock
  // ---------------------------------------------------------------------------
  int          m_cnt  [NC];
  bit          m_pend [NC];
  bit          m_prev [NC];
  logic        m_busy = 1'b0;
  int          m_start = 0;
  int          m_cyc = 0;
  logic [3:0]  m_sel = '0;
  logic [3:0]  m_req_sel = '0;
  logic        m_tmo = 1'b0, m_rng = 1'b0, m_berr = 1'b0;
  logic [31:0] m_scr = '0;
  logic        exp_wack = 1'b0, exp_rack = 1'b0;
  logic [31:0] exp_rdata = '0;

  function automatic logic [31:0] mread(input logic [7:0] a);
    int off, p;
    logic [31:0] v;
    v = 32'd0;
    if (a == 8'h00)      v = 32'h0001_0061;
    else if (a == 8'h01) v = m_scr;
    else if (a == 8'h02) v = (NC << 8) | NP;
    else if (a == 8'h04) v = {28'd0, m_req_sel};
    else if (a == 8'h05) v = {20'd0, m_berr, m_rng, m_tmo, m_busy, 4'd0, m_sel};
    else if (a >= 8'h10 && int'(a) < 16 + 2 * NP) begin
      off = int'(a) - 16;
      p   = off / 2;
      if (off % 2 == 0) v = ((32'h40 + p) << 24) | ((32'h30 + p) << 16) | ((32'h20 + p) << 8) | (32'h10 + p);
      else              v = ((32'h60 + p) << 8) | (32'h50 + p);
    end
    else if (a >= 8'h40 && int'(a) < 64 + NC) v = 32'(m_cnt[int'(a) - 64]);
    return v;
  endfunction

  initial forever begin
    bit rd_hit, wr_hit, was_busy;
    logic [7:0] wa;
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_busy = 0; m_sel = 0; m_req_sel = 0; m_tmo = 0; m_rng = 0; m_berr = 0;
      m_scr = 0; m_cyc = 0; m_start = 0;
      exp_wack = 0; exp_rack = 0; exp_rdata = 0;
      for (int c = 0; c < NC; c++) begin m_cnt[c] = 0; m_pend[c] = 0; m_prev[c] = 0; end
    end else begin
      m_cyc++;
      rd_hit = up_rreq && (up_raddr[9:8] == WIN);
      wr_hit = up_wreq && (up_waddr[9:8] == WIN);
      wa     = up_waddr[7:0];
      exp_rack  = rd_hit;
      exp_rdata = rd_hit ? mread(up_raddr[7:0]) : 32'd0;
      exp_wack  = wr_hit;
      for (int c = 0; c < NC; c++) begin
        if (wr_hit && wa == 8'h08 && up_wdata[c]) m_cnt[c] = 0;
        else if (m_pend[c] && m_cnt[c] < CMAX)     m_cnt[c]++;
        m_pend[c] = pn_err[c] && !m_prev[c];
        m_prev[c] = pn_err[c];
      end
      was_busy = m_busy;
      if (wr_hit && wa == 8'h05) begin
        if (up_wdata[9])  m_tmo  = 0;
        if (up_wdata[10]) m_rng  = 0;
        if (up_wdata[11]) m_berr = 0;
      end
      if (was_busy) begin
        if (profile_ack) begin m_busy = 0; m_sel = m_req_sel; end
        else if (m_cyc - m_start == TMO) begin m_busy = 0; m_tmo = 1; end
      end
      if (wr_hit && wa == 8'h04) begin
        if (was_busy) m_berr = 1;
        else if (int'(up_wdata[3:0]) < NP) begin m_busy = 1; m_req_sel = up_wdata[3:0]; m_start = m_cyc; end
        else m_rng = 1;
      end
      if (wr_hit && wa == 8'h01) m_scr = up_wdata;
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("wack", 32'(up_wack), 32'(exp_wack));
      chk("rack", 32'(up_rack), 32'(exp_rack));
      chk("rdata", up_rdata, exp_rdata);
      chk("profile_req", 32'(profile_req), 32'(m_busy));
      chk("profile_req_sel", 32'(profile_req_sel), 32'(m_req_sel));
      chk("up_profile_sel", 32'(up_profile_sel), 32'(m_sel));
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks (called at a negedge, return at the negedge of the ack cycle)
  // ---------------------------------------------------------------------------
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    up_wreq = 1'b1; up_waddr = {WIN, a}; up_wdata = d;
    @(negedge clk);
    up_wreq = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    up_rreq = 1'b1; up_raddr = {WIN, a};
    @(negedge clk);
    up_rreq = 1'b0;
    d = up_rdata;
  endtask

  logic [7:0] addr_tbl [18] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h04, 8'h04, 8'h05, 8'h08, 8'h09,
                                8'h10, 8'h15, 8'h17, 8'h18, 8'h40, 8'h41, 8'h43, 8'h44, 8'h7F};

  initial begin
    logic [31:0] d;
    int hi;
    for (int p = 0; p < NP; p++) begin
      jesd_m[8*p +: 8]  = 8'(8'h10 + p);
      jesd_l[8*p +: 8]  = 8'(8'h20 + p);
      jesd_s[8*p +: 8]  = 8'(8'h30 + p);
      jesd_f[8*p +: 8]  = 8'(8'h40 + p);
      jesd_n[8*p +: 8]  = 8'(8'h50 + p);
      jesd_np[8*p +: 8] = 8'(8'h60 + p);
    end
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk_en = 1'b1;

    // Reset state
    chk("rst_req", 32'(profile_req), 32'd0);
    chk("rst_sel", 32'(up_profile_sel), 32'd0);
    rd(8'h05, d); chk("rst_status", d, 32'd0);
    rd(8'h01, d); chk("rst_scratch", d, 32'd0);

    // Basic bus
    rd(8'h00, d); chk("version", d, 32'h0001_0061);
    wr(8'h01, 32'hA5A5_5A5A);
    rd(8'h01, d); chk("scratch", d, 32'hA5A5_5A5A);
    rd(8'h02, d); chk("config", d, 32'h0000_0404);
    rd(8'h14, d); chk("prof2_fslm", d, 32'h4232_2212);
    rd(8'h15, d); chk("prof2_npn", d, 32'h0000_6252);
    rd(8'h18, d); chk("prof4_absent", d, 32'd0);
    up_rreq = 1'b1; up_raddr = 10'h000;
    @(negedge clk);
    up_rreq = 1'b0;
    chk("oow_rack", 32'(up_rack), 32'd0);
    chk("oow_rdata", up_rdata, 32'd0);

    // Handshake with ack
    hi = 0;
    wr(8'h04, 32'd2);
    for (int i = 0; i < 8; i++) begin
      if (profile_req) hi++;
      profile_ack = (i == 3);
      @(negedge clk);
    end
    profile_ack = 1'b0;
    chk("ack_req_cycles", 32'(hi), 32'd4);
    chk("ack_sel", 32'(up_profile_sel), 32'd2);
    rd(8'h05, d); chk("ack_status", d, 32'h0000_0002);

    // Range error
    wr(8'h04, 32'd5);
    chk("range_no_req", 32'(profile_req), 32'd0);
    rd(8'h05, d); chk("range_sticky", d, 32'h0000_0402);
    wr(8'h05, 32'h400);
    rd(8'h05, d); chk("range_w1c", d, 32'h0000_0002);

    // Timeout with a busy-error write in the middle
    hi = 0;
    wr(8'h04, 32'd1);
    for (int i = 0; i < 30; i++) begin
      if (profile_req) hi++;
      up_wreq = (i == 5); up_waddr = {WIN, 8'h04}; up_wdata = 32'd3;
      @(negedge clk);
    end
    up_wreq = 1'b0;
    chk("tmo_req_cycles", 32'(hi), 32'd16);
    chk("tmo_sel_kept", 32'(up_profile_sel), 32'd2);
    rd(8'h05, d); chk("tmo_status", d, 32'h0000_0A02);
    rd(8'h04, d); chk("tmo_req_sel", d, 32'd1);
    wr(8'h05, 32'hE00);
    rd(8'h05, d); chk("tmo_w1c", d, 32'h0000_0002);

    // PN counters
    for (int i = 0; i < 20; i++) begin
      pn_err[1] = 1'b1; @(negedge clk);
      pn_err[1] = 1'b0; @(negedge clk);
    end
    repeat (2) @(negedge clk);
    rd(8'h41, d); chk("pn_saturate", d, 32'd15);
    rd(8'h40, d); chk("pn_other_ch", d, 32'd0);
    wr(8'h08, 32'h2);
    rd(8'h41, d); chk("pn_clear", d, 32'd0);
    pn_err[1] = 1'b1;
    repeat (10) @(negedge clk);
    pn_err[1] = 1'b0;
    repeat (3) @(negedge clk);
    rd(8'h41, d); chk("pn_level_once", d, 32'd1);
    pn_err[1] = 1'b1;
    @(negedge clk);
    wr(8'h08, 32'h2);
    pn_err[1] = 1'b0;
    repeat (3) @(negedge clk);
    rd(8'h41, d); chk("pn_clr_vs_edge", d, 32'd0);
    rd(8'h44, d); chk("pn_absent_ch", d, 32'd0);
    rd(8'h08, d); chk("pnclr_reads0", d, 32'd0);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      up_wreq = ($urandom_range(0, 2) == 0);
      a = addr_tbl[$urandom_range(0, 17)];
      up_waddr = {(($urandom_range(0, 7) == 0) ? 2'h2 : WIN), a};
      up_wdata = (a == 8'h04) ? 32'($urandom_range(0, 7)) : $urandom;
      up_rreq = ($urandom_range(0, 1) == 0);
      up_raddr = {(($urandom_range(0, 7) == 0) ? 2'h0 : WIN), addr_tbl[$urandom_range(0, 17)]};
      if ($urandom_range(0, 2) == 0) pn_err = pn_err ^ NC'($urandom);
      profile_ack = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    up_wreq = 1'b0; up_rreq = 1'b0; profile_ack = 1'b0; pn_err = '0;
    repeat (TMO + 2) @(negedge clk);

    // Asynchronous reset during a handshake
    wr(8'h01, 32'h1234_5678);
    wr(8'h04, 32'd3);
    @(negedge clk);
    chk("pre_rst_req", 32'(profile_req), 32'd1);
    #2 rstn = 1'b0;
    #1 chk("async_rst_req", 32'(profile_req), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    rd(8'h01, d); chk("post_rst_scratch", d, 32'd0);
    rd(8'h05, d); chk("post_rst_status", d, 32'd0);
    rd(8'h04, d); chk("post_rst_psel", d, 32'd0);
    rd(8'h41, d); chk("post_rst_pn", d, 32'd0);
    chk("post_rst_sel", 32'(up_profile_sel), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
